// File: rtl/gpio_irq_ctrl_coalesce.sv
// GPIO interrupt controller: per-bit edge/level detection, sticky raw and
// overflow status with software clear/set, per-bit masking and per-group
// IRQ outputs delayed by a shared coalescing timeout.
module gpio_irq_ctrl_coalesce #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_GRP = 4,
    parameter int unsigned TMR_W   = 16
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic [WIDTH-1:0]   gpio_in,
    input  logic [WIDTH-1:0]   int_type,
    input  logic [WIDTH-1:0]   int_pol,
    input  logic [WIDTH-1:0]   int_both,
    input  logic [WIDTH-1:0]   int_mask,
    input  logic [WIDTH-1:0]   status_w1c,
    input  logic [WIDTH-1:0]   status_w1s,
    input  logic [WIDTH-1:0]   ovf_w1c,
    input  logic [TMR_W-1:0]   coal_timeout,
    output logic [WIDTH-1:0]   raw_status,
    output logic [WIDTH-1:0]   masked_status,
    output logic [WIDTH-1:0]   ovf_status,
    output logic [NUM_GRP-1:0] grp_irq,
    output logic               irq
);

    localparam int unsigned GW = WIDTH / NUM_GRP;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        FIRE
    } grp_state_t;

    logic [WIDTH-1:0]   prev;
    logic               primed;
    logic [WIDTH-1:0]   rise;
    logic [WIDTH-1:0]   fall;
    logic [WIDTH-1:0]   edge_evt;
    logic [WIDTH-1:0]   level_evt;
    logic [WIDTH-1:0]   set_vec;
    logic [WIDTH-1:0]   ovf_set;
    logic [WIDTH-1:0]   raw_next;
    logic [WIDTH-1:0]   ovf_next;

    grp_state_t         state    [NUM_GRP];
    grp_state_t         state_nx [NUM_GRP];
    logic [TMR_W-1:0]   cnt      [NUM_GRP];
    logic [TMR_W-1:0]   cnt_nx   [NUM_GRP];
    logic [NUM_GRP-1:0] act;
    logic [NUM_GRP-1:0] grp_irq_nx;

    // Input history; primed stays low until the first edge after reset so
    // an input held high through reset never looks like a rise.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            prev   <= '0;
            primed <= 1'b0;
        end else begin
            prev   <= gpio_in;
            primed <= 1'b1;
        end
    end

    // Per-bit event detection and next status values (set wins over clear).
    always_comb begin
        rise      = gpio_in & ~prev;
        fall      = ~gpio_in & prev;
        edge_evt  = ~int_type & {WIDTH{primed}} &
                    ((int_both & (rise | fall)) |
                     (~int_both & int_pol & fall) |
                     (~int_both & ~int_pol & rise));
        level_evt = int_type & ~(gpio_in ^ int_pol);
        set_vec   = edge_evt | level_evt | status_w1s;
        raw_next  = (raw_status | set_vec) & ~(status_w1c & ~set_vec);
        ovf_set   = (edge_evt | status_w1s) & raw_status & ~status_w1c;
        ovf_next  = (ovf_status | ovf_set) & ~(ovf_w1c & ~ovf_set);
    end

    // Sticky raw and overflow status registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            raw_status <= '0;
            ovf_status <= '0;
        end else begin
            raw_status <= raw_next;
            ovf_status <= ovf_next;
        end
    end

    assign masked_status = raw_status & int_mask;
    assign irq           = |grp_irq;

    // Group FSM state, counter and registered IRQ outputs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int unsigned g = 0; g < NUM_GRP; g++) begin
                state[g] <= IDLE;
                cnt[g]   <= '0;
            end
            grp_irq <= '0;
        end else begin
            for (int unsigned g = 0; g < NUM_GRP; g++) begin
                state[g] <= state_nx[g];
                cnt[g]   <= cnt_nx[g];
            end
            grp_irq <= grp_irq_nx;
        end
    end

    // Group next-state: arm on any unmasked pending bit, fire once the counter
    // matches the timeout (counter wraps freely if the timeout is lowered).
    always_comb begin
        for (int unsigned g = 0; g < NUM_GRP; g++) begin
            act[g]      = |masked_status[g*GW +: GW];
            state_nx[g] = state[g];
            cnt_nx[g]   = cnt[g];
            case (state[g])
                IDLE: begin
                    if (act[g]) begin
                        if (coal_timeout == '0) begin
                            state_nx[g] = FIRE;
                        end else begin
                            state_nx[g] = ARMED;
                            cnt_nx[g]   = TMR_W'(1);
                        end
                    end
                end
                ARMED: begin
                    if (!act[g]) begin
                        state_nx[g] = IDLE;
                        cnt_nx[g]   = '0;
                    end else if (cnt[g] == coal_timeout) begin
                        state_nx[g] = FIRE;
                    end else begin
                        cnt_nx[g] = cnt[g] + TMR_W'(1);
                    end
                end
                FIRE: begin
                    if (!act[g]) begin
                        state_nx[g] = IDLE;
                        cnt_nx[g]   = '0;
                    end
                end
                default: begin
                    state_nx[g] = IDLE;
                    cnt_nx[g]   = '0;
                end
            endcase
        end
    end

    // IRQ output is the registered "next state is FIRE" decode.
    always_comb begin
        for (int unsigned g = 0; g < NUM_GRP; g++) begin
            grp_irq_nx[g] = (state_nx[g] == FIRE);
        end
    end

endmodule

// File: tb/tb_gpio_irq_ctrl_coalesce.sv
// Directed bench for gpio_irq_ctrl_coalesce; expected values are queued with
// the edge at which they must be visible and compared by a monitor.
module tb_gpio_irq_ctrl_coalesce;

    localparam int W  = 32;
    localparam int G  = 4;
    localparam int TW = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic [W-1:0]  gpio_in, int_type, int_pol, int_both, int_mask;
    logic [W-1:0]  status_w1c, status_w1s, ovf_w1c;
    logic [TW-1:0] coal_timeout;
    logic [W-1:0]  raw_status, masked_status, ovf_status;
    logic [G-1:0]  grp_irq;
    logic          irq;

    gpio_irq_ctrl_coalesce #(.WIDTH(W), .NUM_GRP(G), .TMR_W(TW)) dut (
        .PCLK          (PCLK),
        .PRESETn       (PRESETn),
        .gpio_in       (gpio_in),
        .int_type      (int_type),
        .int_pol       (int_pol),
        .int_both      (int_both),
        .int_mask      (int_mask),
        .status_w1c    (status_w1c),
        .status_w1s    (status_w1s),
        .ovf_w1c       (ovf_w1c),
        .coal_timeout  (coal_timeout),
        .raw_status    (raw_status),
        .masked_status (masked_status),
        .ovf_status    (ovf_status),
        .grp_irq       (grp_irq),
        .irq           (irq)
    );

    always #5 PCLK = ~PCLK;

    int edges = 0;
    always @(posedge PCLK) edges <= edges + 1;

    // kind: 0 raw_status, 1 ovf_status, 2 grp_irq, 3 irq, 4 masked_status
    typedef struct {
        int          due;
        string       tag;
        int          kind;
        logic [31:0] m;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_at(input int due, input string tag, input int kind,
                             input logic [31:0] m, input logic [31:0] v);
        exp_t e;
        int   i;
        e.due = due; e.tag = tag; e.kind = kind; e.m = m; e.v = v;
        i = 0;
        while (i < sb.size() && sb[i].due <= due) i++;
        sb.insert(i, e);
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            0:       return raw_status;
            1:       return ovf_status;
            2:       return 32'(grp_irq);
            3:       return 32'(irq);
            4:       return masked_status;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Compare every expectation whose edge has been reached.
    always @(negedge PCLK) begin : mon
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= edges) begin
            e = sb.pop_front();
            check(e.tag, observe(e.kind) & e.m, e.v & e.m);
        end
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_reset(input logic [W-1:0] g);
        gpio_in = g;
        #2 PRESETn = 1'b0;
        repeat (3) tick();
        PRESETn = 1'b1;
        repeat (2) tick();
    endtask

    int base;

    initial begin
        PRESETn = 1'b1;
        gpio_in = '0; int_type = '0; int_pol = '0; int_both = '0; int_mask = '1;
        status_w1c = '0; status_w1s = '0; ovf_w1c = '0; coal_timeout = '0;
        #2 PRESETn = 1'b0;
        #1;
        check("rst_raw", raw_status, 32'h0);
        check("rst_ovf", ovf_status, 32'h0);
        check("rst_grp", 32'(grp_irq), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        repeat (2) tick();
        PRESETn = 1'b1;
        repeat (3) tick();

        // 1: rise on bit 5, T=0
        gpio_in[5] = 1'b1;
        expect_at(edges + 1, "t1_raw5",     0, 32'h20, 32'h20);
        expect_at(edges + 1, "t1_grp0_lo",  2, 32'h1,  32'h0);
        expect_at(edges + 2, "t1_grp0_hi",  2, 32'h1,  32'h1);
        expect_at(edges + 2, "t1_irq",      3, 32'h1,  32'h1);
        repeat (3) tick();
        status_w1c[5] = 1'b1;
        expect_at(edges + 1, "t1_raw5_clr", 0, 32'h20, 32'h0);
        expect_at(edges + 1, "t1_grp0_hold",2, 32'h1,  32'h1);
        expect_at(edges + 2, "t1_grp0_drop",2, 32'h1,  32'h0);
        tick();
        status_w1c = '0;
        repeat (3) tick();

        // mid-operation asynchronous reset, then 2: inputs high through reset
        status_w1s = '1;
        expect_at(edges + 1, "t2_pre_raw", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        status_w1s = '0;
        @(negedge PCLK);
        #2 PRESETn = 1'b0;
        gpio_in = '1;
        #1;
        check("mid_rst_raw", raw_status, 32'h0);
        check("mid_rst_ovf", ovf_status, 32'h0);
        check("mid_rst_grp", 32'(grp_irq), 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);
        repeat (2) tick();
        PRESETn = 1'b1;
        for (int k = 1; k <= 3; k++)
            expect_at(edges + k, "t2_no_rise", 0, 32'hFFFF_FFFF, 32'h0);
        repeat (4) tick();

        // 3: bit 9 both edges, overflow then ovf clear
        do_reset('0);
        int_both[9] = 1'b1;
        tick();
        gpio_in[9] = 1'b1;
        expect_at(edges + 1, "t3_raw9",      0, 32'h200, 32'h200);
        expect_at(edges + 1, "t3_ovf9_lo",   1, 32'h200, 32'h0);
        repeat (2) tick();
        gpio_in[9] = 1'b0;
        expect_at(edges + 1, "t3_ovf9_fall", 1, 32'h200, 32'h200);
        repeat (2) tick();
        gpio_in[9] = 1'b1;
        expect_at(edges + 1, "t3_ovf9_rise", 1, 32'h200, 32'h200);
        expect_at(edges + 1, "t3_raw9_hold", 0, 32'h200, 32'h200);
        repeat (2) tick();
        ovf_w1c[9] = 1'b1;
        expect_at(edges + 1, "t3_ovf9_clr",  1, 32'h200, 32'h0);
        expect_at(edges + 1, "t3_raw9_kept", 0, 32'h200, 32'h200);
        tick();
        ovf_w1c = '0;
        tick();

        // 4: bit 3 level-high
        do_reset('0);
        int_both = '0;
        int_type[3] = 1'b1;
        int_pol[3]  = 1'b1;
        tick();
        gpio_in[3] = 1'b1;
        expect_at(edges + 1, "t4_raw3", 0, 32'h8, 32'h8);
        repeat (2) tick();
        status_w1c[3] = 1'b1;
        expect_at(edges + 1, "t4_raw3_resist", 0, 32'h8, 32'h8);
        expect_at(edges + 1, "t4_ovf3_a",      1, 32'h8, 32'h0);
        tick();
        status_w1c = '0;
        tick();
        gpio_in[3] = 1'b0;
        expect_at(edges + 1, "t4_raw3_sticky", 0, 32'h8, 32'h8);
        repeat (2) tick();
        status_w1c[3] = 1'b1;
        expect_at(edges + 1, "t4_raw3_clr", 0, 32'h8, 32'h0);
        expect_at(edges + 1, "t4_ovf3_b",   1, 32'h8, 32'h0);
        tick();
        status_w1c = '0;
        repeat (2) tick();

        // 5: coalescing T=8 on group 2 via W1S of bit 17
        do_reset('0);
        int_type = '0; int_pol = '0;
        coal_timeout = TW'(8);
        repeat (2) tick();
        base = edges;
        status_w1s[17] = 1'b1;
        expect_at(base + 1,  "t5_raw17",   0, 32'h2_0000, 32'h2_0000);
        expect_at(base + 9,  "t5_grp2_lo", 2, 32'h4, 32'h0);
        expect_at(base + 10, "t5_grp2_hi", 2, 32'h4, 32'h4);
        tick();
        status_w1s = '0;
        repeat (12) tick();
        status_w1c[17] = 1'b1;
        tick();
        status_w1c = '0;
        repeat (3) tick();
        base = edges;
        status_w1s[17] = 1'b1;
        tick();
        status_w1s = '0;
        repeat (3) tick();
        status_w1c[17] = 1'b1;
        expect_at(base + 5,  "t5_raw17_clr", 0, 32'h2_0000, 32'h0);
        expect_at(base + 10, "t5_abort_a",   2, 32'h4, 32'h0);
        expect_at(base + 12, "t5_abort_b",   2, 32'h4, 32'h0);
        tick();
        status_w1c = '0;
        repeat (10) tick();
        base = edges;
        status_w1s[17] = 1'b1;
        expect_at(base + 9,  "t5_rearm_lo", 2, 32'h4, 32'h0);
        expect_at(base + 10, "t5_rearm_hi", 2, 32'h4, 32'h4);
        tick();
        status_w1s = '0;
        repeat (12) tick();

        // 6: rise coincident with W1C, bit masked off
        do_reset('0);
        coal_timeout = '0;
        int_mask[0] = 1'b0;
        tick();
        gpio_in[0] = 1'b1;
        status_w1c[0] = 1'b1;
        expect_at(edges + 1, "t6_raw0",    0, 32'h1, 32'h1);
        expect_at(edges + 1, "t6_masked0", 4, 32'h1, 32'h0);
        for (int k = 1; k <= 3; k++)
            expect_at(edges + k, "t6_irq_lo", 3, 32'h1, 32'h0);
        tick();
        status_w1c = '0;
        repeat (6) tick();

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
